// File: rtl/pair_framer_if.sv
`default_nettype none
// ============================================================================
//  Module      : pair_framer_if
//  Description : Bus bundle for pair_framer. Carries the serial complex-sample
//                input handshake and the registered (X0, X1) pair output
//                handshake.
//                  master : the side that drives samples and consumes pairs
//                  slave  : the pair_framer itself
//                Signals:
//                  in_valid / in_ready / in_real / in_im    sample input
//                  pair_valid / pair_ready                  pair handshake
//                  X0_Real, X0_Im, X1_Real, X1_Im           pair operands
//                  pair_last                                last pair of frame
//  Revision    : 1.0  initial release
// ============================================================================
interface pair_framer_if #(
    parameter int DATA_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_real;
    logic [DATA_W-1:0] in_im;
    logic              pair_valid;
    logic              pair_ready;
    logic [DATA_W-1:0] X0_Real;
    logic [DATA_W-1:0] X0_Im;
    logic [DATA_W-1:0] X1_Real;
    logic [DATA_W-1:0] X1_Im;
    logic              pair_last;

    modport master (
        output in_valid, in_real, in_im, pair_ready,
        input  in_ready, pair_valid, X0_Real, X0_Im, X1_Real, X1_Im, pair_last
    );

    modport slave (
        input  in_valid, in_real, in_im, pair_ready,
        output in_ready, pair_valid, X0_Real, X0_Im, X1_Real, X1_Im, pair_last
    );
endinterface
`default_nettype wire

// File: rtl/pair_framer.sv
`default_nettype none
// ============================================================================
//  Module      : pair_framer
//  Description : Groups a serial stream of complex samples into (X0, X1)
//                pairs for a combinational 2-point butterfly. One staging
//                register holds a pending X0, one pair register holds the
//                presented operands. Pairs are tagged with pair_last on the
//                final pair of each frame of PAIRS_PER_FRAME pairs.
//  Ports       : clk           clock, rising edge
//                rst           synchronous active-high reset
//                bus (slave)   sample input handshake + pair output handshake
//  Options     : PAIR_FRAMER_SCALE_EN - when defined, every component is
//                arithmetic-shifted right by one bit (floor divide by two)
//                on entry to the staging/pair register.
//  Revision    : 1.0  initial release
// ============================================================================
module pair_framer #(
    parameter int DATA_W          = 16,
    parameter int PAIRS_PER_FRAME = 4
) (
    input  wire          clk,
    input  wire          rst,
    pair_framer_if.slave bus
);

    localparam int c_CNT_W = (PAIRS_PER_FRAME > 1) ? $clog2(PAIRS_PER_FRAME) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(PAIRS_PER_FRAME - 1);

    // State encoding: bit 1 doubles as pair_valid, and only FULL_X0 blocks input.
    localparam logic [1:0] c_EMPTY   = 2'b00;
    localparam logic [1:0] c_HAVE_X0 = 2'b01;
    localparam logic [1:0] c_FULL    = 2'b10;
    localparam logic [1:0] c_FULL_X0 = 2'b11;

    logic [1:0]         r_state;
    logic [DATA_W-1:0]  r_stage_re;
    logic [DATA_W-1:0]  r_stage_im;
    logic [DATA_W-1:0]  r_x0_re;
    logic [DATA_W-1:0]  r_x0_im;
    logic [DATA_W-1:0]  r_x1_re;
    logic [DATA_W-1:0]  r_x1_im;
    logic [c_CNT_W-1:0] r_cnt;

    logic               w_in_ready;
    logic               w_pair_valid;
    logic               w_accept;
    logic               w_handshake;
    logic [DATA_W-1:0]  w_in_re;
    logic [DATA_W-1:0]  w_in_im;

    // Optional 1-bit headroom guard; sign-replicating shift rounds toward -inf.
    function automatic logic [DATA_W-1:0] f_scale(input logic [DATA_W-1:0] v);
`ifdef PAIR_FRAMER_SCALE_EN
        return {v[DATA_W-1], v[DATA_W-1:1]};
`else
        return v;
`endif
    endfunction

    // Handshake outputs decode from the state register only.
    assign w_in_ready   = (r_state != c_FULL_X0);
    assign w_pair_valid = r_state[1];
    assign w_accept     = bus.in_valid & w_in_ready;
    assign w_handshake  = w_pair_valid & bus.pair_ready;
    assign w_in_re      = f_scale(bus.in_real);
    assign w_in_im      = f_scale(bus.in_im);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_EMPTY;
            r_stage_re <= '0;
            r_stage_im <= '0;
            r_x0_re    <= '0;
            r_x0_im    <= '0;
            r_x1_re    <= '0;
            r_x1_im    <= '0;
            r_cnt      <= '0;
        end else begin
            if (w_handshake) begin
                r_cnt <= (r_cnt == c_LAST) ? '0 : r_cnt + 1'b1;
            end

            case (r_state)
                c_EMPTY: begin
                    if (w_accept) begin
                        r_stage_re <= w_in_re;
                        r_stage_im <= w_in_im;
                        r_state    <= c_HAVE_X0;
                    end
                end
                c_HAVE_X0: begin
                    if (w_accept) begin
                        r_x0_re <= r_stage_re;
                        r_x0_im <= r_stage_im;
                        r_x1_re <= w_in_re;
                        r_x1_im <= w_in_im;
                        r_state <= c_FULL;
                    end
                end
                c_FULL: begin
                    // Any accepted sample here is the X0 of the next pair.
                    if (w_accept) begin
                        r_stage_re <= w_in_re;
                        r_stage_im <= w_in_im;
                    end
                    case ({w_handshake, w_accept})
                        2'b11:   r_state <= c_HAVE_X0;
                        2'b10:   r_state <= c_EMPTY;
                        2'b01:   r_state <= c_FULL_X0;
                        default: r_state <= c_FULL;
                    endcase
                end
                default: begin // c_FULL_X0: staged X0 is kept across the handshake
                    if (w_handshake) begin
                        r_state <= c_HAVE_X0;
                    end
                end
            endcase
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.pair_valid = w_pair_valid;
    assign bus.X0_Real    = r_x0_re;
    assign bus.X0_Im      = r_x0_im;
    assign bus.X1_Real    = r_x1_re;
    assign bus.X1_Im      = r_x1_im;
    // The counter only moves on a handshake, so this stays stable while presented.
    assign bus.pair_last  = (r_cnt == c_LAST);

endmodule
`default_nettype wire
